// File: rtl/fifo_wr_arb.sv
// Packet-locked round-robin arbiter sharing one async-FIFO write port among NREQ requesters.
// Optional macro FIFO_WR_ARB_PRIO0_EN: requester 0 wins every IDLE arbitration it requests.
module fifo_wr_arb #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int CNTW  = 16
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       gnt,
  output logic [DSIZE-1:0]      wdata,
  output logic                  winc,
  input  logic                  wfull,
  output logic [CNTW-1:0]       pkt_cnt,
  output logic [CNTW-1:0]       beat_cnt
);
  localparam int LW = $clog2(NREQ);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_next;
  logic [NREQ-1:0] gnt_next;
  logic [LW-1:0]   last_owner, last_owner_next;
  logic [LW-1:0]   winner, idx;
  logic            pkt_done;

  // Write side is a pure function of the registered owner, so no winc can slip out in IDLE.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that skips an assignment infers a latch.
    ack      = gnt & req & {NREQ{~wfull}};
    winc     = |ack;
    pkt_done = |(ack & req_last);
    wdata    = '0;
    for (int i = 0; i < NREQ; i++)
      wdata = wdata | (req_data[i*DSIZE +: DSIZE] & {DSIZE{gnt[i]}});
  end

  // Scan downward so the candidate closest to last_owner+1 is the one that sticks.
  always_comb begin
    winner = last_owner;
    idx    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = LW'((int'(last_owner) + k) % NREQ);
      if (req[idx]) winner = idx;
    end
`ifdef FIFO_WR_ARB_PRIO0_EN
    if (req[0]) winner = '0;
`endif
  end

  always_comb begin
    state_next      = state;
    gnt_next        = gnt;
    last_owner_next = last_owner;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_next = BUSY;
          gnt_next   = NREQ'(1) << winner;
`ifdef FIFO_WR_ARB_PRIO0_EN
          if (winner != '0) last_owner_next = winner;
`else
          last_owner_next = winner;
`endif
        end
      end
      BUSY: begin
        if (pkt_done) begin
          state_next = IDLE;
          gnt_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      // NOTE: reset is synchronous here; the FIFO itself keeps beats already written.
      state      <= IDLE;
      gnt        <= '0;
      last_owner <= LW'(NREQ - 1);
      pkt_cnt    <= '0;
      beat_cnt   <= '0;
    end else begin
      state      <= state_next;
      gnt        <= gnt_next;
      last_owner <= last_owner_next;
      if (winc)     beat_cnt <= beat_cnt + CNTW'(1);
      if (pkt_done) pkt_cnt  <= pkt_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: packet-level reference model checked every cycle, plus directed scenarios.
module tb_fifo_wr_arb;
  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int CNTW  = 16;

  logic                  wclk = 1'b0;
  logic                  wrst = 1'b1;
  logic                  wfull = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ-1:0]       req_last = '0;
  logic [NREQ*DSIZE-1:0] req_data = '0;
  logic [NREQ-1:0]       ack, gnt;
  logic [DSIZE-1:0]      wdata;
  logic                  winc;
  logic [CNTW-1:0]       pkt_cnt, beat_cnt;

  int errors = 0;
  int checks = 0;

  fifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .CNTW(CNTW)) dut (
    .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .gnt(gnt), .wdata(wdata), .winc(winc), .wfull(wfull),
    .pkt_cnt(pkt_cnt), .beat_cnt(beat_cnt)
  );

  always #5 wclk = ~wclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester sources: each sends npk packets of plen beats, data = base + incr*beat_index.
  int          npk  [NREQ] = '{default: 0};
  int          plen [NREQ] = '{default: 1};
  int          bidx [NREQ] = '{default: 0};
  logic [7:0]  base [NREQ] = '{default: 8'h00};
  bit          pause[NREQ] = '{default: 1'b0};
  logic [7:0]  incr = 8'h00;
  logic [NREQ-1:0] ack_seen = '0;

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i]      = (npk[i] > 0) && !pause[i];
      req_last[i] = (bidx[i] == plen[i] - 1);
      req_data[i*DSIZE +: DSIZE] = base[i] + 8'(int'(incr) * bidx[i]);
    end
  endtask

  task automatic load(input int i, input int n, input int len, input logic [7:0] b);
    npk[i]  = n;
    plen[i] = len;
    bidx[i] = 0;
    base[i] = b;
    drive();
  endtask

  // Advance one clock; retire the beat each requester saw acknowledged, then re-drive.
  task automatic step();
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (ack_seen[i]) begin
        bidx[i]++;
        if (bidx[i] == plen[i]) begin
          bidx[i] = 0;
          npk[i]--;
        end
      end
    end
    drive();
  endtask

  // Reference model: who owns the port, whose turn is next, and the two counts.
  bit              mon_en  = 1'b0;
  int              m_owner = -1;
  int              m_last  = NREQ - 1;
  logic [CNTW-1:0] m_pkt   = '0;
  logic [CNTW-1:0] m_beat  = '0;
  int              glog[$];
  logic [7:0]      wlog[$];
  int              eg[$];
  logic [7:0]      ew[$];
  int              winc_cnt = 0;
  logic [NREQ-1:0] prev_gnt = '0;

  always @(negedge wclk) begin
    logic            acc;
    logic [NREQ-1:0] e_ack, e_gnt;
    int              w;
    if (mon_en) begin
      acc   = 1'b0;
      e_ack = '0;
      e_gnt = '0;
      if (m_owner >= 0) begin
        acc = req[m_owner] && !wfull;
        e_gnt[m_owner] = 1'b1;
        e_ack[m_owner] = acc;
        check("wdata", wdata, req_data[m_owner*DSIZE +: DSIZE]);
      end
      check("gnt", gnt, e_gnt);
      check("ack", ack, e_ack);
      check("winc", winc, acc);
      check("pkt_cnt", pkt_cnt, m_pkt);
      check("beat_cnt", beat_cnt, m_beat);

      ack_seen = ack;
      if (winc) begin
        wlog.push_back(wdata);
        winc_cnt++;
      end
      if (gnt != '0 && prev_gnt == '0) glog.push_back(int'(gnt));
      prev_gnt = gnt;

      if (wrst) begin
        m_owner = -1;
        m_last  = NREQ - 1;
        m_pkt   = '0;
        m_beat  = '0;
      end else if (m_owner < 0) begin
        if (req != '0) begin
          w = -1;
`ifdef FIFO_WR_ARB_PRIO0_EN
          if (req[0]) w = 0;
`endif
          for (int k = 1; k <= NREQ && w < 0; k++)
            if (req[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
          m_owner = w;
`ifdef FIFO_WR_ARB_PRIO0_EN
          if (w != 0) m_last = w;
`else
          m_last = w;
`endif
        end
      end else if (acc) begin
        m_beat++;
        if (req_last[m_owner]) begin
          m_pkt++;
          m_owner = -1;
        end
      end
    end
  end

  function automatic bit pending();
    pending = 1'b0;
    for (int i = 0; i < NREQ; i++) if (npk[i] > 0) pending = 1'b1;
  endfunction

  task automatic run_idle(input string name, input int max);
    int n;
    n = 0;
    while ((pending() || m_owner >= 0) && n < max) begin
      step();
      n++;
    end
    check({name, "_timeout"}, (pending() || m_owner >= 0), 0);
  endtask

  task automatic clear_logs();
    glog.delete();
    wlog.delete();
    eg.delete();
    ew.delete();
    winc_cnt = 0;
  endtask

  task automatic cmp_logs(input string name);
    check({name, "_grant_count"}, glog.size(), eg.size());
    for (int i = 0; i < eg.size() && i < glog.size(); i++)
      check($sformatf("%s_grant%0d", name, i), glog[i], eg[i]);
    check({name, "_write_count"}, wlog.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wlog.size(); i++)
      check($sformatf("%s_write%0d", name, i), wlog[i], ew[i]);
  endtask

  initial begin
    drive();
    @(posedge wclk);
    #1;
    mon_en = 1'b1;
    step();
    wrst = 1'b0;
    @(negedge wclk);
    check("rst_gnt", gnt, 0);
    check("rst_winc", winc, 0);
    check("rst_pkt", pkt_cnt, 0);
    check("rst_beat", beat_cnt, 0);

    // S1: all four send a 2-beat packet; 3 cycles each, grants 0,1,2,3.
    clear_logs();
    incr = 8'h00;
    for (int i = 0; i < NREQ; i++) load(i, 1, 2, 8'(32'hA0 + i));
    repeat (11) step();
    @(negedge wclk);
    check("s1_pkt_cycle11", pkt_cnt, 3);
    step();
    @(negedge wclk);
    check("s1_pkt_cycle12", pkt_cnt, 4);
    check("s1_beat", beat_cnt, 8);
    check("s1_winc_cycles", winc_cnt, 8);
    eg = '{1, 2, 4, 8};
    ew = '{8'hA0, 8'hA0, 8'hA1, 8'hA1, 8'hA2, 8'hA2, 8'hA3, 8'hA3};
    cmp_logs("s1");

    // S2: requester 2, 4 beats, FIFO full on BUSY cycles 2-3.
    clear_logs();
    incr = 8'h01;
    load(2, 1, 4, 8'hB0);
    step();
    step();
    wfull = 1'b1;
    @(negedge wclk);
    check("s2_gnt_stall", gnt, 4'b0100);
    check("s2_winc_stall", winc, 0);
    check("s2_ack_stall", ack, 0);
    step();
    @(negedge wclk);
    check("s2_winc_stall2", winc, 0);
    step();
    wfull = 1'b0;
    run_idle("s2", 20);
    check("s2_winc_cycles", winc_cnt, 4);
    eg = '{4};
    ew = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    cmp_logs("s2");

    // S3: requester 1 holds the port while 3 and 0 wait; 3 goes next, then 0.
    clear_logs();
    load(1, 1, 3, 8'hC0);
    step();
    load(3, 1, 1, 8'hD0);
    load(0, 1, 1, 8'hE0);
    run_idle("s3", 40);
    eg = '{2, 8, 1};
    ew = '{8'hC0, 8'hC1, 8'hC2, 8'hD0, 8'hE0};
    cmp_logs("s3");

    // S4: requester 0 drops req for 5 cycles mid-packet; requester 2 must wait.
    clear_logs();
    load(0, 1, 3, 8'h10);
    step();
    load(2, 1, 1, 8'h20);
    step();
    pause[0] = 1'b1;
    drive();
    for (int c = 0; c < 5; c++) begin
      @(negedge wclk);
      check($sformatf("s4_gnt_hold%0d", c), gnt, 4'b0001);
      check($sformatf("s4_winc_hold%0d", c), winc, 0);
      step();
    end
    pause[0] = 1'b0;
    drive();
    run_idle("s4", 40);
    eg = '{1, 4};
    ew = '{8'h10, 8'h11, 8'h12, 8'h20};
    cmp_logs("s4");

    // S5: reset during beat 2 of a 3-beat packet; requester 0 wins next.
    clear_logs();
    load(1, 1, 3, 8'h30);
    step();
    step();
    wrst = 1'b1;
    step();
    wrst = 1'b0;
    npk[1]  = 0;
    bidx[1] = 0;
    drive();
    @(negedge wclk);
    check("s5_gnt_after_rst", gnt, 0);
    check("s5_winc_after_rst", winc, 0);
    check("s5_pkt_after_rst", pkt_cnt, 0);
    check("s5_beat_after_rst", beat_cnt, 0);
    step();
    load(1, 1, 1, 8'h40);
    load(0, 1, 1, 8'h50);
    run_idle("s5", 40);
    @(negedge wclk);
    check("s5_pkt_final", pkt_cnt, 2);
    check("s5_beat_final", beat_cnt, 2);
    eg = '{2, 1, 2};
    ew = '{8'h30, 8'h31, 8'h50, 8'h40};
    cmp_logs("s5");

    // S6: everybody streams three 1-beat packets after a fresh reset.
    wrst = 1'b1;
    step();
    wrst = 1'b0;
    clear_logs();
    incr = 8'h00;
    for (int i = 0; i < NREQ; i++) load(i, 3, 1, 8'(32'h60 + i));
    run_idle("s6", 100);
`ifdef FIFO_WR_ARB_PRIO0_EN
    eg = '{1, 1, 1, 2, 4, 8, 2, 4, 8, 2, 4, 8};
`else
    eg = '{1, 2, 4, 8, 1, 2, 4, 8, 1, 2, 4, 8};
`endif
    foreach (eg[i]) ew.push_back(8'(32'h60 + $clog2(eg[i])));
    cmp_logs("s6");
    @(negedge wclk);
    check("s6_pkt", pkt_cnt, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Round-robin write-port arbiter in front of one async FIFO write side; shares a single FIFO write port among NREQ requesters.
- Runs entirely in the FIFO write-clock domain.
- Grants whole packets: once a requester owns the port it keeps it until its last beat is written.
- Drives the FIFO write data and write increment, and back-pressures requesters on the FIFO full flag.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DSIZE, 8, data width; must equal the FIFO data width.
- CNTW, 16, width of the packet and beat statistics counters.

Ports:
- wclk  input  1  write-domain clock; all logic is on its rising edge.
- wrst  input  1  synchronous active-high reset.
- req  input  NREQ  per-requester beat-valid; must stay high from first to last beat of a packet.
- req_data  input  NREQ*DSIZE  flattened beat data; requester i uses bits [i*DSIZE +: DSIZE].
- req_last  input  NREQ  marks the final beat of a packet; sampled with req.
- ack  output  NREQ  beat accepted this cycle; one-hot or zero.
- gnt  output  NREQ  registered one-hot owner of the port; zero when idle.
- wdata  output  DSIZE  to FIFO write data.
- winc  output  1  to FIFO write increment.
- wfull  input  1  from FIFO full flag.
- pkt_cnt  output  CNTW  count of completed packets, wraps.
- beat_cnt  output  CNTW  count of accepted beats, wraps.

Behaviour:
- Reset (wrst=1 at a wclk edge):
  - State goes to IDLE; gnt=0, ack=0, winc=0, pkt_cnt=0, beat_cnt=0.
  - Round-robin pointer last_owner is set to NREQ-1, so requester 0 wins first.
  - A reset mid-packet abandons the packet. No further winc is issued; the FIFO keeps any beats already written.
- State machine has two states, IDLE and BUSY.
- IDLE:
  - If any req bit is high, pick the first requester with req high, searching from last_owner+1 upward modulo NREQ.
  - On the next edge: gnt is set one-hot to the winner, last_owner is updated to the winner, and state goes to BUSY.
  - If no req bit is high, stay in IDLE.
  - winc is 0 in IDLE, so arbitration costs one cycle.
- BUSY, owner o:
  - accept = req[o] & ~wfull, combinational.
  - winc = accept; ack[o] = accept; wdata = req_data slice o, driven combinationally from the registered gnt.
  - On accept with req_last[o]=1: pkt_cnt increments, state goes to IDLE, and gnt clears on the next edge.
  - Requesters never win back-to-back without an IDLE cycle between packets.
  - If req[o] drops mid-packet, the port stays locked to o with winc=0 until req[o] returns.
  - Requests from non-owners are ignored and their ack stays 0.
- beat_cnt increments on every accept.
- Both counters wrap from 2^CNTW-1 to 0.
- wfull is honoured in the same cycle, so winc is never asserted while wfull=1. The FIFO never sees an overflow attempt.
- A single-beat packet (req and req_last high together) takes 1 arbitration cycle plus 1 write cycle.
- Every output except winc, ack and wdata is registered. winc, ack and wdata depend combinationally only on gnt, req, req_data and wfull.

Optional Feature:
- Macro FIFO_WR_ARB_PRIO0_EN.
- Defined: in IDLE, requester 0 wins whenever req[0]=1, regardless of last_owner. The other requesters keep round-robin among themselves; last_owner is updated only when a non-zero requester wins. Packet locking is unchanged, so requester 0 cannot pre-empt a packet in progress.
- Undefined: pure round-robin as described above, and requester 0 has no special handling.

Test Plan:
- Reset, then req=4'b1111, each requester sending a 2-beat packet with data 8'hA0+i (wfull=0) -> gnt order 0,1,2,3. Each packet takes 3 cycles (1 arb + 2 writes); winc is high for 8 cycles total; pkt_cnt=4; beat_cnt=8.
- Requester 2 sends a 4-beat packet while wfull is forced high on cycles 2-3 of BUSY -> winc=0 and ack=0 during those cycles. gnt stays 4'b0100. All 4 beats are written in order; no winc with wfull=1.
- Requester 1 is mid-packet while req[3] is high -> ack[3]=0 until requester 1's last beat. Requester 3 is granted on the next arbitration, ahead of requester 0.
- Requester 0 drops req for 5 cycles mid-packet -> gnt stays 4'b0001 and winc=0. The packet resumes when req[0] returns; no other requester is granted.
- wrst is asserted during beat 2 of a 3-beat packet -> next cycle gnt=0, winc=0, pkt_cnt=0. The next grant goes to requester 0 if it is requesting.
- With FIFO_WR_ARB_PRIO0_EN defined: req=4'b1111 continuously with 1-beat packets -> requester 0 wins every arbitration. Otherwise, with req[0] low, requesters 1,2,3 rotate round-robin.
